// File: rtl/uart_rx_mmio_fifo.sv
// uart_rx_mmio_fifo: receive FIFO between the UART receiver and the CPU MMIO path.
// UART bytes are pushed into a circular buffer. The CPU polls status and pops data
// through memory-mapped registers whose reads return one cycle later.
// Optional feature: define UART_RX_STATS_EN to add a saturating count of accepted
// bytes at BASE_ADDR+0x14.
module uart_rx_mmio_fifo #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_din,
    output logic [31:0] mmio_dout,
    input  logic        stall
);

    localparam int          CNT_W        = ADDR_W + 1;
    localparam logic [31:0] RX_CTRL_ADDR = BASE_ADDR + 32'h04;
    localparam logic [31:0] RX_DATA_ADDR = BASE_ADDR + 32'h0C;
    localparam logic [31:0] RX_CMD_ADDR  = BASE_ADDR + 32'h10;
`ifdef UART_RX_STATS_EN
    localparam logic [31:0] RX_STAT_ADDR = BASE_ADDR + 32'h14;
`endif

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full_hold_q, full_hold_d;  // valid was seen while full last cycle
    logic [31:0]       mmio_dout_q, mmio_dout_d;
`ifdef UART_RX_STATS_EN
    logic [15:0]       stats_q, stats_d;
`endif

    logic        full, empty, push, pop, cmd_wr, flush, clr_ovf;
    logic [7:0]  count_byte;
    logic [31:0] rd_value;
    logic        unused_din;

    assign unused_din      = ^mmio_din[31:2];
    assign uart_dout_ready = !rst && !full;
    assign mmio_dout       = mmio_dout_q;

    // Decode handshakes and CPU commands; stall suppresses every CPU-side effect.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later lines see earlier results.
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        cmd_wr     = (|mmio_we) && !stall && (mmio_addr == RX_CMD_ADDR);
        flush      = cmd_wr && mmio_din[0];
        clr_ovf    = cmd_wr && mmio_din[1];
        push       = uart_dout_valid && !full && !flush;  // flush discards a same-cycle byte
        pop        = mmio_re && !stall && (mmio_addr == RX_DATA_ADDR) && !empty;
        count_byte = 8'(count_q);
    end

    // Next-state for pointers, occupancy, overflow tracking and statistics.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        full_hold_d = uart_dout_valid && full;
        overflow_d  = overflow_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
        // Second consecutive valid-while-full cycle means the UART may be losing bytes.
        if (uart_dout_valid && full && full_hold_q) overflow_d = 1'b1;
        if (clr_ovf) overflow_d = 1'b0;  // an explicit clear wins over a same-cycle set
`ifdef UART_RX_STATS_EN
        stats_d = stats_q;
        if (clr_ovf)                            stats_d = '0;
        else if (push && stats_q != 16'hFFFF)   stats_d = stats_q + 16'd1;
`endif
    end

    // Register-map read mux; the read data register only loads on an unstalled read.
    always_comb begin
        rd_value = '0;
        case (mmio_addr)
            RX_CTRL_ADDR: rd_value = {16'b0, count_byte, 5'b0, overflow_q, full, !empty};
            RX_DATA_ADDR: if (!empty) rd_value = {24'b0, mem_q[rd_ptr_q]};
`ifdef UART_RX_STATS_EN
            RX_STAT_ADDR: rd_value = {16'b0, stats_q};
`endif
            default:      rd_value = '0;
        endcase
        mmio_dout_d = mmio_dout_q;
        if (mmio_re && !stall) mmio_dout_d = rd_value;
    end

    // FIFO storage write port.
    // NOTE: the data array has no reset; contents are meaningless until count says otherwise.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= uart_dout;
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            full_hold_q <= 1'b0;
            mmio_dout_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            full_hold_q <= full_hold_d;
            mmio_dout_q <= mmio_dout_d;
        end
    end

`ifdef UART_RX_STATS_EN
    // Accepted-byte statistics counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stats_q <= '0;
        else     stats_q <= stats_d;
    end
`endif

endmodule

// File: tb/tb_uart_rx_mmio_fifo.sv
// Self-checking bench for uart_rx_mmio_fifo. Inputs change on the falling edge and
// outputs are sampled on the following falling edge. Expected read results go into a
// scoreboard queue when a read is issued and are compared when each scenario drains it.
module tb_uart_rx_mmio_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h04;
    localparam logic [31:0] A_DATA = BASE + 32'h0C;
    localparam logic [31:0] A_CMD  = BASE + 32'h10;
    localparam logic [31:0] A_STAT = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;
    logic [31:0] mmio_addr;
    logic        mmio_re;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_din;
    logic [31:0] mmio_dout;
    logic        stall;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    logic [7:0]  model_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    uart_rx_mmio_fifo #(.DEPTH(16), .ADDR_W(4), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_dout       (uart_dout),
        .uart_dout_valid (uart_dout_valid),
        .uart_dout_ready (uart_dout_ready),
        .mmio_addr       (mmio_addr),
        .mmio_re         (mmio_re),
        .mmio_we         (mmio_we),
        .mmio_din        (mmio_din),
        .mmio_dout       (mmio_dout),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ctrl_exp(input int n, input bit ovf);
        logic [7:0] nb;
        nb = 8'(n);
        return {16'b0, nb, 5'b0, ovf, (n == 16), (n != 0)};
    endfunction

    // One read cycle: entered and left on a falling edge; result lands in obs_q.
    task automatic rd(input logic [31:0] a, input logic st, input string nm, input logic [31:0] e);
        mmio_addr = a; mmio_re = 1'b1; stall = st;
        @(negedge clk);
        mmio_re = 1'b0; stall = 1'b0;
        exp_q.push_back('{nm, e});
        obs_q.push_back(mmio_dout);
    endtask

    // Read RX_DATA and predict the head byte from the model, popping it.
    task automatic rd_pop(input string nm);
        logic [31:0] e;
        e = (model_q.size() != 0) ? {24'b0, model_q.pop_front()} : 32'h0;
        rd(A_DATA, 1'b0, nm, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic st);
        mmio_addr = a; mmio_din = d; mmio_we = 4'hF; stall = st;
        @(negedge clk);
        mmio_we = 4'h0; stall = 1'b0;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            uart_dout = first + 8'(i);
            uart_dout_valid = 1'b1;
            @(negedge clk);
            if (model_q.size() < 16) model_q.push_back(first + 8'(i));
        end
        uart_dout_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (uart_dout_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 0", uart_dout_ready);
        end
        tests_run++;
        if (mmio_dout !== 32'h0) begin
            tests_failed++; $display("FAIL reset_dout: got %h expected 0", mmio_dout);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (uart_dout_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ready_after_reset: got %b expected 1", uart_dout_ready);
        end
        @(negedge clk);
        rd(A_CTRL, 1'b0, "reset_ctrl", 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_basic();
        exp_t e; logic [31:0] o;
        push_bytes(1, 8'h41);
        push_bytes(1, 8'h42);
        rd_pop("data_41");
        rd_pop("data_42");
        rd(A_CTRL, 1'b0, "ctrl_empty", ctrl_exp(model_q.size(), 1'b0));
        push_bytes(1, 8'h33);
        rd(BASE + 32'h08, 1'b0, "unmapped_08", 32'h0);
        rd(BASE, 1'b0, "unmapped_00", 32'h0);
        rd(A_STAT, 1'b0, "stats_pre_clear", 32'h0);  // cleared: nothing accepted is counted yet? see below
        rd_pop("data_33");
        rd_pop("data_empty");
        rd(A_CTRL, 1'b0, "ctrl_after_empty_read", 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
`ifdef UART_RX_STATS_EN
            if (e.name == "stats_pre_clear") e.val = 32'd3;
`endif
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_full_overflow();
        exp_t e; logic [31:0] o;
        push_bytes(16, 8'h00);
        tests_run++;
        if (uart_dout_ready !== 1'b0) begin
            tests_failed++; $display("FAIL ready_when_full: got %b expected 0", uart_dout_ready);
        end
        rd(A_CTRL, 1'b0, "ctrl_full", 32'h0000_1003);
        push_bytes(1, 8'hAA);  // one valid-while-full cycle is not yet an overflow
        rd(A_CTRL, 1'b0, "ctrl_full_one_cycle", 32'h0000_1003);
        push_bytes(2, 8'hAA);
        rd(A_CTRL, 1'b0, "ctrl_overflow", 32'h0000_1007);
        rd_pop("pop_after_full");
        tests_run++;
        if (uart_dout_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ready_after_pop: got %b expected 1", uart_dout_ready);
        end
        rd(A_CTRL, 1'b0, "ctrl_sticky_ovf", ctrl_exp(model_q.size(), 1'b1));
        wr(A_CMD, 32'h3, 1'b0);
        model_q.delete();
        rd(A_CTRL, 1'b0, "ctrl_after_cmd3", 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_stall();
        exp_t e; logic [31:0] o;
        push_bytes(2, 8'h51);
        rd(A_CTRL, 1'b0, "ctrl_two", 32'h0000_0201);
        for (int i = 0; i < 3; i++) rd(A_DATA, 1'b1, "stall_hold", 32'h0000_0201);
        wr(A_CMD, 32'h1, 1'b1);  // stalled flush must be ignored
        rd_pop("unstalled_pop");
        rd(A_CTRL, 1'b0, "ctrl_one_pop", ctrl_exp(model_q.size(), 1'b0));
        wr(A_CMD, 32'h1, 1'b0);
        model_q.delete();
        rd(A_CTRL, 1'b0, "ctrl_after_flush", 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_push_pop_flush();
        exp_t e; logic [31:0] o;
        push_bytes(5, 8'h70);
        uart_dout = 8'h75; uart_dout_valid = 1'b1;
        rd_pop("simul_pop");
        uart_dout_valid = 1'b0;
        model_q.push_back(8'h75);
        rd(A_CTRL, 1'b0, "ctrl_count5", 32'h0000_0501);
        uart_dout = 8'h99; uart_dout_valid = 1'b1;
        wr(A_CMD, 32'h1, 1'b0);  // flush wins over the same-cycle push
        uart_dout_valid = 1'b0;
        model_q.delete();
        rd(A_CTRL, 1'b0, "ctrl_flush_push", 32'h0);
        rd_pop("data_after_flush");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; logic [31:0] o;
        push_bytes(3, 8'h21);
        rd_pop("data_before_rst");
        uart_dout = 8'h44; uart_dout_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (uart_dout_ready !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_ready: got %b expected 0", uart_dout_ready);
        end
        tests_run++;
        if (mmio_dout !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_dout: got %h expected 0", mmio_dout);
        end
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        @(negedge clk);
        uart_dout_valid = 1'b0;
        model_q.push_back(8'h44);
        rd(A_CTRL, 1'b0, "ctrl_after_midrst", 32'h0000_0101);
        rd_pop("reoffered_byte");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_stats_wrap();
        exp_t e; logic [31:0] o;
        logic [31:0] stat_exp;
`ifdef UART_RX_STATS_EN
        stat_exp = 32'd21;  // the re-offered byte after reset plus 20 below
`else
        stat_exp = 32'd0;
`endif
        for (int i = 0; i < 20; i++) begin
            push_bytes(1, 8'(8'h60 + i));
            if (i % 2 == 1) rd_pop("wrap_pop");
        end
        rd(A_STAT, 1'b0, "stats_count", stat_exp);
        wr(A_CMD, 32'h2, 1'b0);
        rd(A_STAT, 1'b0, "stats_cleared", 32'h0);
        while (model_q.size() != 0) rd_pop("wrap_drain");
        rd(A_CTRL, 1'b0, "ctrl_drained", 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e.val) begin tests_failed++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
        end
    endtask

    initial begin
        rst = 1'b1; uart_dout = '0; uart_dout_valid = 1'b0;
        mmio_addr = '0; mmio_re = 1'b0; mmio_we = '0; mmio_din = '0; stall = 1'b0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_stall();
        test_push_pop_flush();
        test_mid_reset();
        test_stats_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
